// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared data-cache constants and FSM state type
//   WORDS_PER_LINE - 32-bit words per cache line
//   BYTE_W/OFFSET_W/LINE_LSB - byte, word-offset and line-offset address widths
//   state_t        - controller states IDLE, REFILL, WRITE
package mips_mem_pkg;
    localparam int WORDS_PER_LINE = 4;
    localparam int BYTE_W         = 2;
    localparam int OFFSET_W       = 2;
    localparam int LINE_LSB       = BYTE_W + OFFSET_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for the direct-mapped data cache
//   clk, rst_n          - clock, async active-low reset (clears valid bits only)
//   i_idx, i_off        - combinational read port: line index and word offset
//   o_valid/o_tag/o_word - selected line state and word
//   i_we, i_wr_off, i_wdata - word write into line i_idx
//   i_fill, i_wtag      - line fill completion: store tag, set valid
module dcache_array
    import mips_mem_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WPL   = 4,
    parameter int IW    = 4,
    parameter int TW    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IW-1:0]       i_idx,
    input  logic [OFFSET_W-1:0] i_off,
    output logic                o_valid,
    output logic [TW-1:0]       o_tag,
    output logic [31:0]         o_word,
    input  logic                i_we,
    input  logic [OFFSET_W-1:0] i_wr_off,
    input  logic [31:0]         i_wdata,
    input  logic                i_fill,
    input  logic [TW-1:0]       i_wtag
);
    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [31:0]      r_data [LINES][WPL];

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_word  = r_data[i_idx][i_off];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= '0;
        else if (i_fill)
            r_valid[i_idx] <= 1'b1;
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (i_we)
            r_data[i_idx][i_wr_off] <= i_wdata;
        if (i_fill)
            r_tag[i_idx] <= i_wtag;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller
//   clk, rst_n                 - clock, async active-low reset
//   mem_read, mem_write, addr, write_data - pipeline request (held while hit=0)
//   hit, read_data             - completion/stall and load data to the pipeline
//   mem_req, mem_we, mem_addr, mem_wdata  - word transaction to main memory
//   mem_ready, mem_rdata       - memory word handshake and read data
module dcache_ctrl #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        hit,
    output logic [31:0] read_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    import mips_mem_pkg::*;

    localparam int IW = $clog2(LINES);
    localparam int TW = 32 - LINE_LSB - IW;
    localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(WORDS_PER_LINE - 1);

    state_t              r_state;
    state_t              w_next;
    logic [OFFSET_W-1:0] r_cnt;

    logic [TW-1:0]       w_tag;
    logic [IW-1:0]       w_idx;
    logic [OFFSET_W-1:0] w_off;
    logic                w_valid;
    logic [TW-1:0]       w_rtag;
    logic [31:0]         w_word;
    logic                w_line_hit;
    logic                w_is_rd;
    logic                w_refill;
    logic                w_arr_we;
    logic                w_fill;
    logic                w_unused;

    assign w_tag    = addr[31:LINE_LSB+IW];
    assign w_idx    = addr[LINE_LSB+IW-1:LINE_LSB];
    assign w_off    = addr[LINE_LSB-1:BYTE_W];
    assign w_unused = &{1'b0, addr[BYTE_W-1:0]};

    assign w_line_hit = w_valid && (w_rtag == w_tag);
    // A simultaneous read and write is handled as a write.
    assign w_is_rd    = mem_read && !mem_write;
    assign w_refill   = (r_state == S_REFILL);

    // Refill words always land; a store updates the line only if it is resident.
    assign w_arr_we = mem_ready && (w_refill || (r_state == S_WRITE && w_line_hit));
    assign w_fill   = w_refill && mem_ready && (r_cnt == LAST);

    dcache_array #(
        .LINES (LINES),
        .WPL   (WORDS_PER_LINE),
        .IW    (IW),
        .TW    (TW)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_idx    (w_idx),
        .i_off    (w_off),
        .o_valid  (w_valid),
        .o_tag    (w_rtag),
        .o_word   (w_word),
        .i_we     (w_arr_we),
        .i_wr_off (w_refill ? r_cnt : w_off),
        .i_wdata  (w_refill ? mem_rdata : write_data),
        .i_fill   (w_fill),
        .i_wtag   (w_tag)
    );

    always_comb begin
        hit       = 1'b1;
        read_data = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_next    = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_write) begin
                    hit    = 1'b0;
                    w_next = S_WRITE;
                end else if (w_is_rd) begin
                    hit       = w_line_hit;
                    read_data = w_line_hit ? w_word : '0;
                    w_next    = w_line_hit ? S_IDLE : S_REFILL;
                end
            end
            S_REFILL: begin
                hit      = 1'b0;
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
                w_next   = (mem_ready && r_cnt == LAST) ? S_IDLE : S_REFILL;
            end
            S_WRITE: begin
                hit       = mem_ready;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr[31:2], 2'b00};
                mem_wdata = write_data;
                w_next    = mem_ready ? S_IDLE : S_WRITE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Counter is held at zero in IDLE so every refill starts at word 0.
            r_cnt   <= (r_state == S_IDLE) ? '0 : (w_refill && mem_ready) ? r_cnt + 1'b1 : r_cnt;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with a word-addressed memory model
module tb_dcache_ctrl;
    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        hit;
    logic [31:0] read_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    int          stalls;
    int          hs_rd;
    int          hs_wr;
    int          bad;
    logic [31:0] hs_addr [8];
    logic [31:0] hs_wdata;
    logic [31:0] rdata;

    // Memory: untouched words read as 0x1000_0000 | address, stores override.
    logic [31:0]  wmem [256];
    logic [255:0] wval;
    logic         mem_clr;

    dcache_ctrl #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .hit        (hit),
        .read_data  (read_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr)
            wval <= '0;
        else if (mem_req && mem_we && mem_ready) begin
            wmem[mem_addr[9:2]] <= mem_wdata;
            wval[mem_addr[9:2]] <= 1'b1;
        end
    end

    assign mem_rdata = wval[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : (32'h1000_0000 | mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline access; memory acknowledges after dly wait cycles per word.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int dly);
        int  w;
        bit  done;
        w = 0;
        done = 0;
        stalls = 0;
        hs_rd = 0;
        hs_wr = 0;
        bad = 0;
        rdata = '0;
        hs_wdata = '0;
        mem_read = rd;
        mem_write = wr;
        addr = a;
        write_data = wd;
        for (int c = 0; c < 60 && !done; c++) begin
            mem_ready = mem_req && (w >= dly);
            #1;
            if (mem_req && mem_we && mem_addr !== {a[31:2], 2'b00})
                bad++;
            if (mem_req && mem_ready) begin
                if (hs_rd + hs_wr < 8)
                    hs_addr[hs_rd + hs_wr] = mem_addr;
                if (mem_we) begin
                    hs_wr++;
                    hs_wdata = mem_wdata;
                end else
                    hs_rd++;
                w = 0;
            end else if (mem_req)
                w++;
            if (hit) begin
                done = 1;
                rdata = read_data;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        chk("access_done", 32'(done), 32'd1);
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("idle_hit", 32'(hit), 32'd1);
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("idle_rdata", read_data, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_clr = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = '0;
        write_data = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_hit", 32'(hit), 32'd1);
        chk("rst_rdata", read_data, 32'd0);

        access(1, 0, 32'h40, 0, 0);
        chk("r40_stalls", stalls, 5);
        chk("r40_rd", hs_rd, 4);
        chk("r40_wr", hs_wr, 0);
        chk("r40_a0", hs_addr[0], 32'h40);
        chk("r40_a1", hs_addr[1], 32'h44);
        chk("r40_a2", hs_addr[2], 32'h48);
        chk("r40_a3", hs_addr[3], 32'h4C);
        chk("r40_data", rdata, 32'h1000_0040);

        access(1, 0, 32'h48, 0, 0);
        chk("r48_stalls", stalls, 0);
        chk("r48_rd", hs_rd, 0);
        chk("r48_data", rdata, 32'h1000_0048);

        access(0, 1, 32'h44, 32'hDEAD_BEEF, 3);
        chk("w44_stalls", stalls, 4);
        chk("w44_wr", hs_wr, 1);
        chk("w44_rd", hs_rd, 0);
        chk("w44_addr", hs_addr[0], 32'h44);
        chk("w44_held", bad, 0);
        chk("w44_wdata", hs_wdata, 32'hDEAD_BEEF);

        access(1, 0, 32'h44, 0, 0);
        chk("r44_stalls", stalls, 0);
        chk("r44_data", rdata, 32'hDEAD_BEEF);

        access(1, 0, 32'h140, 0, 0);
        chk("r140_stalls", stalls, 5);
        chk("r140_a0", hs_addr[0], 32'h140);
        chk("r140_a3", hs_addr[3], 32'h14C);
        chk("r140_data", rdata, 32'h1000_0140);

        access(1, 0, 32'h40, 0, 0);
        chk("r40b_stalls", stalls, 5);
        chk("r40b_data", rdata, 32'h1000_0040);

        access(1, 0, 32'h44, 0, 0);
        chk("r44b_stalls", stalls, 0);
        chk("r44b_data", rdata, 32'hDEAD_BEEF);

        // Reset with two refill words already taken.
        mem_read = 1'b1;
        addr = 32'h80;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_addr", mem_addr, 32'h88);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_hit", 32'(hit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_read = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("post_rst_hit", 32'(hit), 32'd1);

        access(1, 0, 32'h80, 0, 0);
        chk("r80_stalls", stalls, 5);
        chk("r80_rd", hs_rd, 4);
        chk("r80_a0", hs_addr[0], 32'h80);
        chk("r80_a3", hs_addr[3], 32'h8C);
        chk("r80_data", rdata, 32'h1000_0080);

        access(1, 0, 32'h48, 0, 0);
        chk("r48c_stalls", stalls, 5);
        chk("r48c_data", rdata, 32'h1000_0048);

        access(0, 1, 32'h200, 32'hCAFE_F00D, 0);
        chk("w200_stalls", stalls, 1);
        chk("w200_wr", hs_wr, 1);
        chk("w200_rd", hs_rd, 0);
        chk("w200_mem", wmem[8'h80], 32'hCAFE_F00D);

        access(1, 0, 32'h200, 0, 0);
        chk("r200_stalls", stalls, 5);
        chk("r200_data", rdata, 32'hCAFE_F00D);

        access(1, 1, 32'h48, 32'h1234_5678, 2);
        chk("rw48_stalls", stalls, 3);
        chk("rw48_wr", hs_wr, 1);
        chk("rw48_rd", hs_rd, 0);

        access(1, 0, 32'h48, 0, 0);
        chk("r48d_stalls", stalls, 0);
        chk("r48d_data", rdata, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
